// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file / scoreboard slice.
//   RF_ADDR_W : default register index width (32 registers)
//   RF_WIDTH  : default data width
//   reg_idx_t : register index type at the default width
//   REG_ZERO  : the hardwired-zero register index
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_WIDTH  = 32;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/busy_table.sv
// Per-register busy scoreboard with an incrementally maintained pending count.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   issue_en, issue_rd   : mark a destination busy
//   wr_en, wr_addr       : writeback, clears the destination's busy bit
//   flush                : clears every busy bit (highest priority)
//   lookup_addr          : NREAD packed indices, ADDR_W bits each
//   lookup_busy          : busy bit for each looked-up index (combinational)
//   pending_cnt          : number of busy registers (registered)
module busy_table
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_rd,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    flush,
  input  logic [NREAD*ADDR_W-1:0] lookup_addr,
  output logic [NREAD-1:0]        lookup_busy,
  output logic [ADDR_W:0]         pending_cnt
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_hit, clr_hit, inc, dec;

  always_comb begin
    set_hit = issue_en && (issue_rd != '0) && !flush;
    // A same-index issue outranks the writeback: the newer producer is still outstanding.
    clr_hit = wr_en && (wr_addr != '0) && !flush && !(set_hit && (issue_rd == wr_addr));
    inc     = set_hit && !busy_q[issue_rd];
    dec     = clr_hit && busy_q[wr_addr];

    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (set_hit) busy_d[issue_rd] = 1'b1;
      if (clr_hit) busy_d[wr_addr]  = 1'b0;
    end
    busy_d[0] = 1'b0;

    // Count tracks popcount(busy) by only counting real 0->1 and 1->0 transitions.
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    lookup_busy = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      lookup_busy[i] = busy_q[lookup_addr[i*ADDR_W +: ADDR_W]];
    end
  end

  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional write-to-read bypass and a
// per-register busy scoreboard. Register 0 reads zero and is never busy.
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data    : writeback
//   issue_en, issue_rd         : destination marked busy at issue
//   flush                      : clears all busy bits
//   rd_addr / rd_data / rd_busy: NREAD packed combinational read ports
//   pending_cnt                : number of busy registers
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_rd,
  input  logic                    flush,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  output logic [NREAD-1:0]        rd_busy,
  output logic [ADDR_W:0]         pending_cnt
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [NREGS-1:0][WIDTH-1:0] mem_q;
  logic                        wr_we;
  logic [NREAD-1:0]            table_busy;

  assign wr_we = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (wr_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  busy_table #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_busy_table (
    .clk         (clk),
    .rst         (rst),
    .issue_en    (issue_en),
    .issue_rd    (issue_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .lookup_addr (rd_addr),
    .lookup_busy (table_busy),
    .pending_cnt (pending_cnt)
  );

  logic [ADDR_W-1:0] port_addr;
  logic              hit;

  always_comb begin
    rd_data   = '0;
    rd_busy   = '0;
    port_addr = '0;
    hit       = 1'b0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      port_addr = rd_addr[i*ADDR_W +: ADDR_W];
      hit       = (BYPASS != 0) && wr_we && (wr_addr == port_addr);
      // Gated by rst so a live write input cannot leak through the bypass during reset.
      if (rst && (port_addr != '0)) begin
        rd_data[i*WIDTH +: WIDTH] = hit ? wr_data : mem_q[port_addr];
        rd_busy[i]                = hit ? 1'b0 : table_busy[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic [5:0]  pend, nb_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.ADDR_W(5), .WIDTH(32), .NREAD(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .pending_cnt(pend)
  );

  regfile_scoreboard #(.ADDR_W(5), .WIDTH(32), .NREAD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .rd_addr(rd_addr),
    .rd_data(nb_rd_data), .rd_busy(nb_rd_busy), .pending_cnt(nb_pend)
  );

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = 5'd3;
    set_rd(5'd5, 5'd3);
    #1;
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, 64'h0); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy: got %b expected 00", rd_busy); end
    step();
    checks++; if (pend !== 6'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pend); end
    checks++; if (nb_rd_data !== 64'h0) begin errors++; $display("FAIL reset_nb_rd_data: got %h expected 0", nb_rd_data); end
    idle();
    rst = 1'b1;
    step();
    set_rd(5'd5, 5'd3);
    #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL reset_r5_after: got %h expected 0", rd_data[31:0]); end
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL reset_r3_busy_after: got %b expected 0", rd_busy[1]); end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    set_rd(5'd7, 5'd0);
    #1;
    checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[31:0]); end
    checks++; if (nb_rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL nobypass_same_cycle: got %h expected 0", nb_rd_data[31:0]); end
    step();
    idle();
    #1;
    checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_stored: got %h expected deadbeef", rd_data[31:0]); end
    checks++; if (nb_rd_data[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_next_cycle: got %h expected deadbeef", nb_rd_data[31:0]); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    set_rd(5'd7, 5'd0);
    #1;
    checks++; if (rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL r0_write_same_cycle: got %h expected 0", rd_data[63:32]); end
    step();
    idle();
    #1;
    checks++; if (rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL r0_write_after: got %h expected 0", rd_data[63:32]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    issue_en = 1'b1; issue_rd = 5'd3;
    set_rd(5'd3, 5'd0);
    #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL issue_same_cycle_busy: got %b expected 0", rd_busy[0]); end
    step();
    idle();
    #1;
    checks++; if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL issue_next_busy: got %b expected 1", rd_busy[0]); end
    checks++; if (pend !== 6'd1) begin errors++; $display("FAIL issue_pending: got %0d expected 1", pend); end
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #1;
    checks++; if (rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_bypass_busy: got %b expected 0", rd_busy[0]); end
    checks++; if (rd_data[31:0] !== 32'h55) begin errors++; $display("FAIL wb_bypass_data: got %h expected 55", rd_data[31:0]); end
    checks++; if (nb_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL wb_nobypass_busy: got %b expected 1", nb_rd_busy[0]); end
    step();
    idle();
    #1;
    checks++; if (pend !== 6'd0) begin errors++; $display("FAIL wb_pending: got %0d expected 0", pend); end
    checks++; if (nb_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL wb_nobypass_busy_next: got %b expected 0", nb_rd_busy[0]); end
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle();
    issue_en = 1'b1; issue_rd = 5'd4;
    step();
    idle();
    issue_en = 1'b1; issue_rd = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h9;
    set_rd(5'd0, 5'd4);
    step();
    idle();
    #1;
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b expected 1", rd_busy[1]); end
    checks++; if (rd_data[63:32] !== 32'h9) begin errors++; $display("FAIL collide_data: got %h expected 9", rd_data[63:32]); end
    checks++; if (pend !== 6'd1) begin errors++; $display("FAIL collide_pending: got %0d expected 1", pend); end
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd2;
    step();
    idle();
    #1;
    checks++; if (pend !== 6'd2) begin errors++; $display("FAIL issue_r2_pending: got %0d expected 2", pend); end
    @(negedge clk);
    issue_en = 1'b1; issue_rd = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
    step();
    idle();
    set_rd(5'd6, 5'd2);
    #1;
    checks++; if (pend !== 6'd2) begin errors++; $display("FAIL cancel_pending: got %0d expected 2", pend); end
    checks++; if (rd_busy !== 2'b01) begin errors++; $display("FAIL cancel_busy: got %b expected 01", rd_busy); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    flush = 1'b1;
    step();
    idle();
    #1;
    checks++; if (pend !== 6'd0) begin errors++; $display("FAIL flush_clear_pending: got %0d expected 0", pend); end
    for (int r = 1; r <= 3; r++) begin
      @(negedge clk);
      issue_en = 1'b1; issue_rd = 5'(r);
    end
    step();
    idle();
    #1;
    checks++; if (pend !== 6'd3) begin errors++; $display("FAIL flush_pre_pending: got %0d expected 3", pend); end
    @(negedge clk);
    flush = 1'b1;
    issue_en = 1'b1; issue_rd = 5'd8;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    step();
    idle();
    set_rd(5'd8, 5'd1);
    #1;
    checks++; if (pend !== 6'd0) begin errors++; $display("FAIL flush_pending: got %0d expected 0", pend); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL flush_busy: got %b expected 00", rd_busy); end
    set_rd(5'd9, 5'd3);
    #1;
    checks++; if (rd_data[31:0] !== 32'h77) begin errors++; $display("FAIL flush_write_data: got %h expected 77", rd_data[31:0]); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL flush_busy2: got %b expected 00", rd_busy); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hA;
    issue_en = 1'b1; issue_rd = 5'd1;
    for (int r = 2; r <= 5; r++) begin
      @(negedge clk);
      idle();
      issue_en = 1'b1; issue_rd = 5'(r);
    end
    step();
    idle();
    set_rd(5'd10, 5'd1);
    #1;
    checks++; if (pend !== 6'd5) begin errors++; $display("FAIL ar_pre_pending: got %0d expected 5", pend); end
    checks++; if (rd_data[31:0] !== 32'hA) begin errors++; $display("FAIL ar_pre_data: got %h expected a", rd_data[31:0]); end
    checks++; if (rd_busy[1] !== 1'b1) begin errors++; $display("FAIL ar_pre_busy: got %b expected 1", rd_busy[1]); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL ar_mid_data: got %h expected 0", rd_data); end
    checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL ar_mid_busy: got %b expected 00", rd_busy); end
    checks++; if (pend !== 6'd0) begin errors++; $display("FAIL ar_mid_pending: got %0d expected 0", pend); end
    #1;
    rst = 1'b1;
    step();
    #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL ar_post_r10: got %h expected 0", rd_data[31:0]); end
    checks++; if (pend !== 6'd0) begin errors++; $display("FAIL ar_post_pending: got %0d expected 0", pend); end
    checks++; if (rd_busy[1] !== 1'b0) begin errors++; $display("FAIL ar_post_busy: got %b expected 0", rd_busy[1]); end
  endtask

  initial begin
    idle();
    rd_addr = '0;
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_collision();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
